// File: rtl/rng_arbiter.sv
// rng_arbiter: round-robin share of one lfsr_rng; STEPS ce pulses per request, then a one-cycle grant.
// Optional macro RNG_ARB_DISTINCT_EN: re-step (up to MAX_RETRY times) when the sample repeats the last grant.
module rng_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int OUT_WIDTH = 9,
  parameter int STEPS     = 8,
  parameter int MAX_RETRY = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [OUT_WIDTH-1:0] value,
  output logic                 busy,
  output logic                 rng_ce,
  input  logic [OUT_WIDTH-1:0] rng_out
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = STEPS > 1 ? $clog2(STEPS + 1) : 1;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STEP   = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] GRANT  = 2'd3;
  if (STEPS < 1) begin : g_steps_chk
    $error("rng_arbiter: STEPS must be >= 1");
  end
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_owner;
  logic [PW-1:0] w_sel;
  logic          w_retry;
  assign busy   = r_state != IDLE;
  assign rng_ce = r_state == STEP;
  // First requester at or after the pointer, wrapping; the lowest offset is assigned last and wins.
  always_comb begin
    w_sel = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[(int'(r_ptr) + i) % NUM_REQ]) w_sel = PW'((int'(r_ptr) + i) % NUM_REQ);
  end
`ifdef RNG_ARB_DISTINCT_EN
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] r_retry;
  assign w_retry = r_state == SETTLE && rng_out == value && int'(r_retry) < MAX_RETRY;
  // Retry budget restarts with every accepted request.
  always_ff @(posedge clk) begin
    if (rst) r_retry <= '0;
    else if (r_state == IDLE && |req) r_retry <= '0;
    else if (w_retry) r_retry <= r_retry + 1'b1;
  end
`else
  assign w_retry = 1'b0;
`endif
  // Arbitration, stepping and grant sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_owner <= '0;
      gnt     <= '0;
      value   <= '0;
    end else begin
      case (r_state)
        IDLE: if (|req) begin
          r_owner <= w_sel;
          r_cnt   <= CW'(STEPS);
          r_state <= STEP;
        end
        STEP: begin
          r_cnt   <= r_cnt - 1'b1;
          r_state <= r_cnt == CW'(1) ? SETTLE : STEP;
        end
        SETTLE: if (w_retry) begin
          r_cnt   <= CW'(1);
          r_state <= STEP;
        end else begin
          value   <= rng_out;
          gnt     <= NUM_REQ'(1) << r_owner;
          r_state <= GRANT;
        end
        default: begin
          gnt     <= '0;
          r_ptr   <= r_owner == PW'(NUM_REQ - 1) ? '0 : r_owner + 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rng_arbiter.sv
// tb_rng_arbiter: randomized self-checking bench for rng_arbiter with a behavioural RNG stub.
module tb_rng_arbiter;
  localparam int STEPS = 8;
  localparam int LAT   = STEPS + 2;
`ifdef RNG_ARB_DISTINCT_EN
  localparam int LAT_REP = STEPS + 2 + 2 * 4;
  localparam int LAT_MOVE = STEPS + 4;
  localparam logic [8:0] V_MOVE = 9'd38;
`else
  localparam int LAT_REP = STEPS + 2;
  localparam int LAT_MOVE = STEPS + 2;
  localparam logic [8:0] V_MOVE = 9'd37;
`endif
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [8:0] value;
  logic       busy;
  logic       rng_ce;
  logic [8:0] rng_out = 9'd100;
  logic       stub_fixed = 1'b0;
  logic [8:0] stub_val = 9'd37;
  int vectors = 0;
  int miscompares = 0;
  int ptr_m = 0;

  rng_arbiter #(.NUM_REQ(4), .OUT_WIDTH(9), .STEPS(STEPS), .MAX_RETRY(4)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .value(value),
    .busy(busy), .rng_ce(rng_ce), .rng_out(rng_out)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] gen();
    logic [8:0] n;
    if (stub_fixed) return stub_val;
    do n = 9'($urandom_range(39, 511)); while (n == value);
    return n;
  endfunction

  always @(posedge clk) if (rng_ce) rng_out <= gen();

  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) if (r[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  task automatic txn(input int drop_at, input int sw_at, input logic [8:0] sw_val,
                     output int lat, output logic [3:0] g, output logic [8:0] v, output logic [8:0] v_ref,
                     output int ces, output int first_ce, output int last_ce,
                     output int busy_lo, output logic busy_after);
    lat = -1; g = '0; v = '0; v_ref = '0; ces = 0; first_ce = -1; last_ce = -1; busy_lo = 0; busy_after = 1'bx;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (k == drop_at) req = '0;
      if (k == sw_at) stub_val = sw_val;
      if (k == last_ce + 1) v_ref = rng_out;
      if (!busy) busy_lo++;
      if (rng_ce) begin ces++; if (first_ce < 0) first_ce = k; last_ce = k; end
      if (gnt != 0) begin lat = k; g = gnt; v = value; req = req & ~gnt; end
    end
    if (lat >= 0) begin @(posedge clk); #1; busy_after = busy; end
  endtask

  task automatic test_reset;
    rst = 1'b1; req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    vectors++; if (gnt !== 4'b0) begin miscompares++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    vectors++; if (value !== 9'd0) begin miscompares++; $display("FAIL reset_value: got %0d want 0", value); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (rng_ce !== 1'b0) begin miscompares++; $display("FAIL reset_rng_ce: got %b want 0", rng_ce); end
    ptr_m = 0;
  endtask

  task automatic test_single;
    int lat, ces, f, l, blo; logic [3:0] g; logic [8:0] v, vr; logic ba;
    req = 4'b0100;
    txn(0, 0, 9'd0, lat, g, v, vr, ces, f, l, blo, ba);
    vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL single_latency: got %0d want %0d", lat, LAT); end
    vectors++; if (g !== 4'b0100) begin miscompares++; $display("FAIL single_gnt: got %b want 0100", g); end
    vectors++; if (ces !== STEPS || f !== 1 || l !== STEPS) begin miscompares++; $display("FAIL single_ce_window: got %0d pulses c%0d..c%0d want %0d pulses c1..c%0d", ces, f, l, STEPS, STEPS); end
    vectors++; if (v !== vr) begin miscompares++; $display("FAIL single_value: got %0d want %0d", v, vr); end
    vectors++; if (blo !== 0) begin miscompares++; $display("FAIL single_busy_during: got %0d idle cycles want 0", blo); end
    vectors++; if (ba !== 1'b0) begin miscompares++; $display("FAIL single_busy_after: got %b want 0", ba); end
    ptr_m = 3;
  endtask

  task automatic test_round_robin;
    int lat, ces, f, l, blo, w; logic [3:0] g; logic [8:0] v, vr; logic ba;
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0; ptr_m = 0;
    req = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      if (n == 4) req = 4'b1001;
      w = pick(req, ptr_m);
      txn(0, 0, 9'd0, lat, g, v, vr, ces, f, l, blo, ba);
      vectors++; if (g !== 4'(1) << w || lat !== LAT) begin miscompares++; $display("FAIL rr_grant%0d: got %b at c%0d want %b at c%0d", n, g, lat, 4'(1) << w, LAT); end
      ptr_m = (w + 1) % 4;
    end
  endtask

  task automatic test_drop;
    int lat, ces, f, l, blo, seen; logic [3:0] g; logic [8:0] v, vr; logic ba;
    req = 4'b0010;
    txn(3, 0, 9'd0, lat, g, v, vr, ces, f, l, blo, ba);
    vectors++; if (g !== 4'b0010 || lat !== LAT) begin miscompares++; $display("FAIL drop_gnt: got %b at c%0d want 0010 at c%0d", g, lat, LAT); end
    seen = 0;
    repeat (15) begin @(posedge clk); #1; if (gnt !== 4'b0 || busy !== 1'b0) seen++; end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL drop_no_regrant: got %0d active cycles want 0", seen); end
    ptr_m = 2;
  endtask

  task automatic test_mid_reset;
    int lat, ces, f, l, blo, seen; logic [3:0] g; logic [8:0] v, vr; logic ba;
    req = 4'b0001;
    repeat (5) begin @(posedge clk); #1; end
    vectors++; if (rng_ce !== 1'b1) begin miscompares++; $display("FAIL midrst_in_step: got rng_ce %b want 1", rng_ce); end
    rst = 1'b1; req = '0;
    @(posedge clk); #1 rst = 1'b0;
    vectors++; if (rng_ce !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL midrst_idle: got ce %b busy %b want 0 0", rng_ce, busy); end
    vectors++; if (value !== 9'd0 || gnt !== 4'b0) begin miscompares++; $display("FAIL midrst_outputs: got value %0d gnt %b want 0 0000", value, gnt); end
    seen = 0;
    repeat (15) begin @(posedge clk); #1; if (gnt !== 4'b0) seen++; end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL midrst_no_gnt: got %0d grants want 0", seen); end
    req = 4'b1000;
    txn(0, 0, 9'd0, lat, g, v, vr, ces, f, l, blo, ba);
    vectors++; if (g !== 4'b1000 || lat !== LAT) begin miscompares++; $display("FAIL midrst_next: got %b at c%0d want 1000 at c%0d", g, lat, LAT); end
    ptr_m = 0;
  endtask

  task automatic test_random;
    int lat, ces, f, l, blo, w; logic [3:0] g; logic [8:0] v, vr; logic ba;
    for (int n = 0; n < 16; n++) begin
      req = req | 4'($urandom_range(0, 15));
      if (req == 4'b0) req = 4'($urandom_range(1, 15));
      w = pick(req, ptr_m);
      txn(0, 0, 9'd0, lat, g, v, vr, ces, f, l, blo, ba);
      vectors++; if (g !== 4'(1) << w) begin miscompares++; $display("FAIL rand%0d_gnt: got %b want %b", n, g, 4'(1) << w); end
      vectors++; if (lat !== LAT || ces !== STEPS) begin miscompares++; $display("FAIL rand%0d_timing: got c%0d %0d pulses want c%0d %0d pulses", n, lat, ces, LAT, STEPS); end
      vectors++; if (v !== vr) begin miscompares++; $display("FAIL rand%0d_value: got %0d want %0d", n, v, vr); end
      vectors++; if (blo !== 0 || ba !== 1'b0) begin miscompares++; $display("FAIL rand%0d_busy: got %0d idle, after %b want 0, 0", n, blo, ba); end
      ptr_m = (w + 1) % 4;
    end
    req = '0;
  endtask

  task automatic test_repeat;
    int lat, ces, f, l, blo; logic [3:0] g; logic [8:0] v, vr; logic ba;
    stub_fixed = 1'b1; stub_val = 9'd37;
    req = 4'b0001;
    txn(0, 0, 9'd0, lat, g, v, vr, ces, f, l, blo, ba);
    vectors++; if (lat !== LAT || v !== 9'd37) begin miscompares++; $display("FAIL rep_first: got c%0d value %0d want c%0d value 37", lat, v, LAT); end
    req = 4'b0010;
    txn(0, 0, 9'd0, lat, g, v, vr, ces, f, l, blo, ba);
    vectors++; if (lat !== LAT_REP || v !== 9'd37) begin miscompares++; $display("FAIL rep_stuck: got c%0d value %0d want c%0d value 37", lat, v, LAT_REP); end
    req = 4'b0100;
    txn(0, 10, 9'd38, lat, g, v, vr, ces, f, l, blo, ba);
    vectors++; if (lat !== LAT_MOVE || v !== V_MOVE) begin miscompares++; $display("FAIL rep_move: got c%0d value %0d want c%0d value %0d", lat, v, LAT_MOVE, V_MOVE); end
    stub_fixed = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_drop;
    test_mid_reset;
    test_random;
    test_repeat;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
